// File: rtl/countdown_timer_param_if.sv
// Control/status bundle between the game control FSM (master) and the countdown timer (slave).
interface countdown_timer_param_if #(
   parameter int CNT_W = 4
);

   logic [CNT_W-1:0] value;
   logic             start;
   logic             pause;
   logic             auto_reload;

   logic [CNT_W-1:0] count;
   logic             running;
   logic             expired;
   logic             expired_pulse;
   logic             tick;
   logic             half_tick;

   modport master (
      output value, start, pause, auto_reload,
      input  count, running, expired, expired_pulse, tick, half_tick
   );

   modport slave (
      input  value, start, pause, auto_reload,
      output count, running, expired, expired_pulse, tick, half_tick
   );

endinterface

// File: rtl/countdown_timer_param.sv
// Countdown timer with programmable tick period, pause/resume and per-tick / half-period enables.
// Define TIMER_AUTORELOAD_EN to compile in the reload register and honour auto_reload.
module countdown_timer_param #(
   parameter int CNT_W       = 4,
   parameter int TICK_CYCLES = 100_000_000,
   parameter int PRE_W       = $clog2(TICK_CYCLES)
) (
   input logic                    clock,
   input logic                    reset,
   countdown_timer_param_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_CYCLES / 2 - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic             tick_q, tick_d;
   logic             half_q, half_d;
   logic             pulse_q, pulse_d;
   logic             running_q;
   logic             expired_q;
   logic             reload_now;
   logic [CNT_W-1:0] reload_value;

`ifdef TIMER_AUTORELOAD_EN
   logic [CNT_W-1:0] reload_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         reload_q <= '0;
      end else if (bus.start) begin
         reload_q <= bus.value;
      end
   end

   assign reload_now   = bus.auto_reload;
   assign reload_value = reload_q;
`else
   logic unused_auto_reload;

   assign unused_auto_reload = bus.auto_reload;
   assign reload_now         = 1'b0;
   assign reload_value       = '0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      half_d  = 1'b0;
      pulse_d = 1'b0;

      if (bus.start) begin
         // A restart discards the prescaler phase; no tick for the abandoned period.
         count_d = bus.value;
         presc_d = '0;
         if (bus.value != '0) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_EXPIRED;
            pulse_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_RUN, ST_PAUSED: begin
               if (bus.pause) begin
                  state_d = ST_PAUSED;
               end else begin
                  state_d = ST_RUN;
                  half_d  = (presc_q == PRE_HALF) || (presc_q == PRE_LAST);
                  if (presc_q == PRE_LAST) begin
                     presc_d = '0;
                     tick_d  = 1'b1;
                     if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                     end
                     if (count_q == CNT_W'(1)) begin
                        pulse_d = 1'b1;
                        if (reload_now) begin
                           count_d = reload_value;
                        end else begin
                           state_d = ST_EXPIRED;
                        end
                     end
                  end else begin
                     presc_d = presc_q + PRE_W'(1);
                  end
               end
            end
            ST_EXPIRED: begin
               count_d = '0;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         presc_q   <= '0;
         tick_q    <= 1'b0;
         half_q    <= 1'b0;
         pulse_q   <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         half_q    <= half_d;
         pulse_q   <= pulse_d;
         running_q <= (state_d == ST_RUN);
         expired_q <= (state_d == ST_EXPIRED);
      end
   end

   assign bus.count         = count_q;
   assign bus.running       = running_q;
   assign bus.expired       = expired_q;
   assign bus.expired_pulse = pulse_q;
   assign bus.tick          = tick_q;
   assign bus.half_tick     = half_q;

endmodule
